// File: rtl/cache_fill_arbiter.sv
// Cache fill arbiter: picks one of two pending cache misses (round-robin on
// a tie) and streams the missing block from memory into the winner's data
// array. On the last word it writes the tag into the victim way, then
// pulses the winner's done for one cycle.
module cache_fill_arbiter #(
   parameter int WORDS  = 8,
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ic_miss,
   input  logic [ADDR_W-1:0]        ic_addr,
   input  logic                     ic_victim,
   input  logic                     dc_miss,
   input  logic [ADDR_W-1:0]        dc_addr,
   input  logic                     dc_victim,
   input  logic                     mem_valid,
   input  logic [15:0]              mem_data,
   output logic                     mem_en,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     fill_sel,
   output logic                     fill_we,
   output logic [$clog2(WORDS)-1:0] fill_word,
   output logic [15:0]              fill_data,
   output logic                     meta_write0,
   output logic                     meta_write1,
   output logic [7:0]               meta_tag,
   output logic                     ic_stall,
   output logic                     dc_stall,
   output logic                     ic_done,
   output logic                     dc_done
);

   localparam int CNT_W = $clog2(WORDS);
   localparam logic [CNT_W:0]    ISSUE_END  = (CNT_W+1)'(WORDS);
   localparam logic [CNT_W-1:0]  RECV_LAST  = CNT_W'(WORDS-1);
   localparam logic [CNT_W:0]    ISSUE_ONE  = (CNT_W+1)'(1);
   localparam logic [CNT_W-1:0]  RECV_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(16'h000F);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t              state, state_nx;
   logic                owner;      // 0 = I-cache, 1 = D-cache
   logic                victim;     // way receiving the metadata write
   logic                last_dc;    // last grant went to the D-cache
   logic [ADDR_W-1:0]   base;       // block-aligned fill address
   logic [CNT_W:0]      issue_cnt;  // reads issued; extra bit marks "all issued"
   logic [CNT_W-1:0]    recv_cnt;   // words returned so far
   logic                grant_en;
   logic                grant_dc;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Grant capture and fill counters; request inputs are ignored after grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= 1'b0;
         victim    <= 1'b0;
         last_dc   <= 1'b0;
         base      <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else if (grant_en) begin
         owner     <= grant_dc;
         last_dc   <= grant_dc;
         base      <= (grant_dc ? dc_addr : ic_addr) & BLOCK_MASK;
         victim    <= grant_dc ? dc_victim : ic_victim;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         if (mem_en)  issue_cnt <= issue_cnt + ISSUE_ONE;
         if (fill_we) recv_cnt  <= recv_cnt + RECV_ONE;
      end
   end

   // Next-state, arbitration and all outputs; everything idles at zero.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nx    = state;
      grant_en    = 1'b0;
      grant_dc    = 1'b0;
      mem_en      = 1'b0;
      mem_addr    = '0;
      fill_sel    = 1'b0;
      fill_we     = 1'b0;
      fill_word   = '0;
      fill_data   = '0;
      meta_write0 = 1'b0;
      meta_write1 = 1'b0;
      meta_tag    = '0;
      ic_done     = 1'b0;
      dc_done     = 1'b0;

      case (state)
         IDLE: begin
            if (ic_miss || dc_miss) begin
               grant_en = 1'b1;
               grant_dc = (ic_miss && dc_miss) ? ~last_dc : dc_miss;
               state_nx = FILL;
            end
         end
         FILL: begin
            fill_sel = owner;
            mem_en   = (issue_cnt < ISSUE_END);
            if (mem_en) mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
            if (mem_valid) begin
               fill_we   = 1'b1;
               fill_word = recv_cnt;
               fill_data = mem_data;
               if (recv_cnt == RECV_LAST) begin
                  meta_write0 = ~victim;
                  meta_write1 = victim;
                  meta_tag    = {base[ADDR_W-1 -: 6], 1'b1, 1'b1};
                  state_nx    = DONE;
               end
            end
         end
         DONE: begin
            fill_sel = owner;
            ic_done  = ~owner;
            dc_done  = owner;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Stall while asking or being filled; released in the owner's DONE cycle.
      ic_stall = rst & ((ic_miss & ~ic_done) | ((state == FILL) & ~owner));
      dc_stall = rst & ((dc_miss & ~dc_done) | ((state == FILL) & owner));
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: directed scenarios push the
// expected memory issues, fill writes, metadata writes and done pulses; a
// monitor pops and compares whenever the DUT presents one. A small memory
// model answers reads with data = addr ^ 16'hA5A5 after a set latency.
module tb_cache_fill_arbiter;

   logic        clk;
   logic        rst;
   logic        ic_miss, dc_miss, ic_victim, dc_victim;
   logic [15:0] ic_addr, dc_addr;
   logic        mem_valid;
   logic [15:0] mem_data;
   logic        mem_en, fill_sel, fill_we, meta_write0, meta_write1;
   logic [15:0] mem_addr, fill_data;
   logic [2:0]  fill_word;
   logic [7:0]  meta_tag;
   logic        ic_stall, dc_stall, ic_done, dc_done;

   cache_fill_arbiter #(.WORDS(8), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst),
      .ic_miss(ic_miss), .ic_addr(ic_addr), .ic_victim(ic_victim),
      .dc_miss(dc_miss), .dc_addr(dc_addr), .dc_victim(dc_victim),
      .mem_valid(mem_valid), .mem_data(mem_data),
      .mem_en(mem_en), .mem_addr(mem_addr),
      .fill_sel(fill_sel), .fill_we(fill_we), .fill_word(fill_word), .fill_data(fill_data),
      .meta_write0(meta_write0), .meta_write1(meta_write1), .meta_tag(meta_tag),
      .ic_stall(ic_stall), .dc_stall(dc_stall), .ic_done(ic_done), .dc_done(dc_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Expected-event queues: {idx,addr}, {sel,word,data}, {w0,w1,tag}, {ic_done,dc_done}.
   logic [18:0] issue_q[$];
   logic [19:0] fill_q[$];
   logic [9:0]  meta_q[$];
   logic [1:0]  done_q[$];

   int n_fill_seen = 0;
   int n_meta_seen = 0;
   int last_issue  = 0;
   int last_meta   = 0;

   // Memory model controls.
   int lat  = 4;
   bit gap  = 1'b0;
   bit spur = 1'b0;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;
   pend_t pend[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_out();
      return {12'h0, mem_en, mem_addr, fill_sel, fill_we, fill_word, fill_data,
              meta_write0, meta_write1, meta_tag, ic_stall, dc_stall, ic_done, dc_done};
   endfunction

   // Expected events of one complete fill of the block holding addr.
   task automatic push_fill(input logic sel, input logic [15:0] addr, input logic vic);
      logic [15:0] b;
      logic [15:0] a;
      b = addr & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
         a = b + 16'(2 * k);
         issue_q.push_back({3'(k), a});
         fill_q.push_back({sel, 3'(k), a ^ 16'hA5A5});
      end
      meta_q.push_back({~vic, vic, b[15:10], 2'b11});
      done_q.push_back(sel ? 2'b01 : 2'b10);
   endtask

   task automatic wait_done(input logic want_dc, input string name);
      int n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!(ic_done || dc_done) && n < 150);
      check(name, {ic_done, dc_done}, want_dc ? 2'b01 : 2'b10);
   endtask

   task automatic wait_fills(input int count, input string name);
      int start = n_fill_seen;
      int n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while ((n_fill_seen - start) < count && n < 100);
      check(name, n_fill_seen - start, count);
   endtask

   // Memory model: records issues, returns data after lat cycles, optionally gapped.
   initial begin : mem_model
      bit prev_v = 1'b0;
      pend_t p;
      mem_valid = 1'b0;
      mem_data  = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         mem_valid = 1'b0;
         mem_data  = '0;
         if (!rst) begin
            pend.delete();
            prev_v = 1'b0;
         end else begin
            if (mem_en) pend.push_back('{addr: mem_addr, due: cyc + lat});
            if (spur) begin
               mem_valid = 1'b1;
               mem_data  = 16'hDEAD;
            end else if (pend.size() > 0 && pend[0].due <= cyc && !(gap && prev_v)) begin
               p = pend.pop_front();
               mem_valid = 1'b1;
               mem_data  = p.addr ^ 16'hA5A5;
            end
            prev_v = mem_valid;
         end
      end
   end

   // Monitor: compares every presented DUT event against the scoreboard.
   initial begin : monitor
      logic [18:0] ei;
      logic [19:0] ef;
      logic [9:0]  em;
      logic [1:0]  ed;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            check("issue_expected", issue_q.size() > 0, 1'b1);
            if (issue_q.size() > 0) begin
               ei = issue_q.pop_front();
               check("issue_addr", mem_addr, ei[15:0]);
               if (ei[18:16] != 3'd0) check("issue_contiguous", cyc, last_issue + 1);
               last_issue = cyc;
            end
         end
         if (fill_we) begin
            n_fill_seen++;
            check("fill_expected", fill_q.size() > 0, 1'b1);
            if (fill_q.size() > 0) begin
               ef = fill_q.pop_front();
               check("fill_sel_word_data", {fill_sel, fill_word, fill_data}, ef);
            end
         end
         if (meta_write0 || meta_write1) begin
            n_meta_seen++;
            check("meta_expected", meta_q.size() > 0, 1'b1);
            if (meta_q.size() > 0) begin
               em = meta_q.pop_front();
               check("meta_way_tag", {meta_write0, meta_write1, meta_tag}, em);
            end
            last_meta = cyc;
         end
         if (ic_done || dc_done) begin
            check("done_expected", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
               ed = done_q.pop_front();
               check("done_owner", {ic_done, dc_done}, ed);
            end
            check("done_after_meta", cyc, last_meta + 1);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int meta_before;
      rst       = 1'b0;
      ic_miss   = 1'b0;
      dc_miss   = 1'b0;
      ic_addr   = '0;
      dc_addr   = '0;
      ic_victim = 1'b0;
      dc_victim = 1'b0;

      // Reset state with a miss already pending: outputs must be zero.
      ic_miss   = 1'b1;
      ic_addr   = 16'h1234;
      ic_victim = 1'b1;
      #3;
      check("reset_outputs_zero", all_out(), 64'h0);
      repeat (2) @(posedge clk);
      #2;
      check("reset_held_zero", all_out(), 64'h0);

      // Single I-cache miss, latency 4: 0x1230..0x123E, meta_write1 tag 0x13.
      lat = 4;
      push_fill(1'b0, 16'h1234, 1'b1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #2;
      check("ic_fill_stalls", {ic_stall, dc_stall}, 2'b10);
      ic_addr   = 16'hBEEF;  // must be ignored after grant
      ic_victim = 1'b0;
      wait_done(1'b0, "ic_done_pulse");
      check("ic_stall_released_in_done", ic_stall, 1'b0);
      ic_miss = 1'b0;

      // Tie from reset: D first, then alternation while both stay asserted.
      @(posedge clk); #2;
      rst = 1'b0;
      ic_miss   = 1'b1;  ic_addr = 16'h0F0F;  ic_victim = 1'b1;
      dc_miss   = 1'b1;  dc_addr = 16'hA5C6;  dc_victim = 1'b0;
      #1;
      check("reset_tie_outputs_zero", all_out(), 64'h0);
      push_fill(1'b1, 16'hA5C6, 1'b0);
      push_fill(1'b0, 16'h0F0F, 1'b1);
      push_fill(1'b1, 16'hFFF2, 1'b1);
      push_fill(1'b0, 16'h0008, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #2;
      check("tie_both_stall", {ic_stall, dc_stall}, 2'b11);
      wait_done(1'b1, "tie1_dc_first");
      dc_addr = 16'hFFF2;  dc_victim = 1'b1;
      wait_done(1'b0, "tie2_ic_next");
      ic_addr = 16'h0008;  ic_victim = 1'b0;
      wait_done(1'b1, "tie3_dc_again");
      dc_miss = 1'b0;
      wait_done(1'b0, "tie4_ic_again");
      ic_miss = 1'b0;

      // Spurious mem_valid in IDLE: nothing may be written.
      @(posedge clk); #2;
      spur = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("spurious_no_write", {fill_we, meta_write0, meta_write1, mem_en}, 4'h0);
      end
      @(posedge clk); #2;
      spur = 1'b0;

      // Gapped memory returns: exactly 8 ordered writes and one meta write.
      lat = 1;
      gap = 1'b1;
      meta_before = n_meta_seen;
      push_fill(1'b1, 16'h8ACE, 1'b0);
      dc_miss = 1'b1;  dc_addr = 16'h8ACE;  dc_victim = 1'b0;
      wait_done(1'b1, "gapped_done");
      dc_miss = 1'b0;
      check("gapped_one_meta", n_meta_seen - meta_before, 1);
      gap = 1'b0;

      // Reset after 3 returned words: abort, then re-grant the held miss from word 0.
      lat = 2;
      @(posedge clk); #2;
      push_fill(1'b1, 16'h4321, 1'b1);
      dc_miss = 1'b1;  dc_addr = 16'h4321;  dc_victim = 1'b1;
      meta_before = n_meta_seen;
      wait_fills(3, "rst_three_words");
      rst = 1'b0;
      #1;
      check("rst_mid_fill_zero", all_out(), 64'h0);
      issue_q.delete();
      fill_q.delete();
      meta_q.delete();
      done_q.delete();
      repeat (3) @(posedge clk);
      #2;
      check("rst_hold_zero", all_out(), 64'h0);
      check("rst_no_meta", n_meta_seen - meta_before, 0);
      push_fill(1'b1, 16'h4321, 1'b1);
      @(negedge clk) rst = 1'b1;
      wait_done(1'b1, "rst_refill_done");
      dc_miss = 1'b0;

      // D miss dropped mid-fill: fill completes, done pulses, stall stays low after.
      lat = 3;
      @(posedge clk); #2;
      push_fill(1'b1, 16'h0FF0, 1'b1);
      dc_miss = 1'b1;  dc_addr = 16'h0FF0;  dc_victim = 1'b1;
      wait_fills(2, "drop_two_words");
      dc_miss = 1'b0;
      #1;
      check("drop_stall_during_fill", dc_stall, 1'b1);
      wait_done(1'b1, "drop_done_pulse");
      repeat (2) @(posedge clk);
      #2;
      check("drop_stall_after", {dc_stall, dc_done, ic_stall}, 3'b000);

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", issue_q.size() + fill_q.size() + meta_q.size() + done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
